// File: rtl/regfile_mt_bypass_if.sv
// Decode/writeback-side bus of the multi-threaded register file.
//   Write side : i_thread_index_writeback, i_write_addr, i_write_data, i_wr_en
//   Read side  : i_thread_index_decode, i_read_addr (5 bits per port), o_read_data
//   Status     : o_init_done (zeroing sweep finished)
// master = core pipeline (drives addresses/data), slave = register file.
interface regfile_mt_bypass_if #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned NUM_THREADS  = 16,
    parameter int unsigned NUM_RD_PORTS = 2
);
    localparam int unsigned TW = $clog2(NUM_THREADS);

    logic [TW-1:0]                  i_thread_index_writeback;
    logic [TW-1:0]                  i_thread_index_decode;
    logic [NUM_RD_PORTS*5-1:0]      i_read_addr;
    logic [4:0]                     i_write_addr;
    logic [DWIDTH-1:0]              i_write_data;
    logic                           i_wr_en;
    logic [NUM_RD_PORTS*DWIDTH-1:0] o_read_data;
    logic                           o_init_done;

    modport master (
        output i_thread_index_writeback,
        output i_thread_index_decode,
        output i_read_addr,
        output i_write_addr,
        output i_write_data,
        output i_wr_en,
        input  o_read_data,
        input  o_init_done
    );

    modport slave (
        input  i_thread_index_writeback,
        input  i_thread_index_decode,
        input  i_read_addr,
        input  i_write_addr,
        input  i_write_data,
        input  i_wr_en,
        output o_read_data,
        output o_init_done
    );
endinterface

// File: rtl/regfile_mt_bypass.sv
// Multi-threaded, multi-read-port register file for the barrel-threaded core.
// NUM_THREADS x 32 registers, replicated into one simple-dual-port bank per
// read port; all banks share the single write port. After reset an INIT sweep
// zeroes every entry, x0 always reads 0, and BYPASS_EN selects write-first
// forwarding for same-cycle write/read collisions.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high
//   bus   - regfile_mt_bypass_if.slave (addresses, write data, read data, init_done)
module regfile_mt_bypass #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned NUM_THREADS  = 16,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned BYPASS_EN    = 1
) (
    input  logic                clk,
    input  logic                reset,
    regfile_mt_bypass_if.slave  bus
);
    localparam int unsigned DEPTH = NUM_THREADS * 32;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     sweep_cnt_q, sweep_cnt_d;
    logic              init_done_q, init_done_d;

    logic              ready_c;
    logic              ext_wr_c;
    logic [AW-1:0]     ext_waddr_c;
    logic              mem_we_c;
    logic [AW-1:0]     mem_waddr_c;
    logic [DWIDTH-1:0] mem_wdata_c;

    logic [DWIDTH-1:0]              port_rd_c [NUM_RD_PORTS];
    logic [NUM_RD_PORTS*DWIDTH-1:0] read_data_c;

    // Physical write address: thread selects a 32-entry window, so threads never alias.
    assign ext_waddr_c = {bus.i_thread_index_writeback, bus.i_write_addr};
    assign ext_wr_c    = bus.i_wr_en && (bus.i_write_addr != 5'd0);
    assign ready_c     = (state_q == ST_READY);

    // State, sweep counter and done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state and shared bank write port selection.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        init_done_d = init_done_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = ext_waddr_c;
        mem_wdata_c = bus.i_write_data;

        case (state_q)
            ST_INIT: begin
                // Sweep owns the write port; external writes are dropped.
                mem_we_c    = 1'b1;
                mem_waddr_c = sweep_cnt_q;
                mem_wdata_c = '0;
                if (sweep_cnt_q == AW'(DEPTH - 1)) begin
                    // Counter holds at the last entry so it never wraps.
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                mem_we_c = ext_wr_c;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Reset beats any write, sweep or external.
        if (reset) begin
            mem_we_c = 1'b0;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
        logic [DWIDTH-1:0] mem [DEPTH];
        logic [DWIDTH-1:0] dob_q;
        logic [DWIDTH-1:0] fwd_data_q;
        logic              not_ready_q;
        logic              x0_q;
        logic              hit_q;
        logic [4:0]        raddr_c;
        logic [AW-1:0]     rphys_c;
        logic              hit_c;

        assign raddr_c = bus.i_read_addr[5*p +: 5];
        assign rphys_c = {bus.i_thread_index_decode, raddr_c};
        assign hit_c   = (BYPASS_EN != 0) && ready_c && ext_wr_c
                         && (ext_waddr_c == rphys_c);

        // Bank: one write port, one registered read port; output register not reset.
        always_ff @(posedge clk) begin
            if (mem_we_c) begin
                mem[mem_waddr_c] <= mem_wdata_c;
            end
            dob_q <= mem[rphys_c];
        end

        // Per-port flags registered alongside the bank read.
        always_ff @(posedge clk) begin
            if (reset) begin
                not_ready_q <= 1'b1;
                x0_q        <= 1'b0;
                hit_q       <= 1'b0;
            end else begin
                not_ready_q <= !ready_c;
                x0_q        <= (raddr_c == 5'd0);
                hit_q       <= hit_c;
            end
        end

        // Forwarded write data; only meaningful when hit_q is set.
        always_ff @(posedge clk) begin
            fwd_data_q <= bus.i_write_data;
        end

        // Output priority: forced zero, then forwarded data, then bank.
        always_comb begin
            port_rd_c[p] = dob_q;
            if (not_ready_q || x0_q) begin
                port_rd_c[p] = '0;
            end else if (hit_q) begin
                port_rd_c[p] = fwd_data_q;
            end
        end
    end

    // Pack per-port results onto the flat read bus.
    always_comb begin
        read_data_c = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            read_data_c[DWIDTH*p +: DWIDTH] = port_rd_c[p];
        end
    end

    assign bus.o_read_data = read_data_c;
    assign bus.o_init_done = init_done_q;
endmodule

// File: doc/regfile_mt_bypass.md
# regfile_mt_bypass

Multi-threaded, multi-read-port register file for the barrel-threaded RISC-V core. It holds NUM_THREADS × 32 architectural registers in replicated BRAM_SDP banks, one bank per read port, all sharing one write port. Beyond a plain banked register file, it adds three things: a post-reset zeroing sweep, hard-wired x0, and an optional same-cycle write-to-read bypass. It sits between decode (read side) and writeback (write side).

## Interface
- DWIDTH, 32, data width of each register
- NUM_THREADS, 16, hardware thread count; power of two, ≥ 2
- NUM_RD_PORTS, 2, number of independent read ports (1–4); one BRAM_SDP bank each
- BYPASS_EN, 1, 1 = write-first forwarding on same-cycle address match; 0 = read-old
- Derived: TW = $clog2(NUM_THREADS); DEPTH = NUM_THREADS*32; AW = $clog2(DEPTH)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- i_thread_index_writeback  in  TW  thread owning the write
- i_thread_index_decode  in  TW  thread owning all reads this cycle
- i_read_addr  in  NUM_RD_PORTS*5  read register indices; port p uses bits [5p+4:5p]
- i_write_addr  in  5  write register index
- i_write_data  in  DWIDTH  write data
- i_wr_en  in  1  write strobe
- o_read_data  out  NUM_RD_PORTS*DWIDTH  read data; port p uses bits [DWIDTH*p+DWIDTH-1:DWIDTH*p]
- o_init_done  out  1  high once the zeroing sweep has completed

## Operation
- **Physical address**
  - Write address: {i_thread_index_writeback, i_write_addr}.
  - Read address for port p: {i_thread_index_decode, i_read_addr[p]}.
  - Threads never alias.
- **FSM**
  - States: INIT and READY.
  - Reset → INIT, sweep counter = 0.
  - INIT, reset low: each cycle, write 0 to entry counter in every bank, then counter += 1.
  - When counter == DEPTH-1 is written: next state is READY and o_init_done = 1.
  - READY persists until reset.
  - Reset in any state, including mid-sweep, returns to INIT with counter 0 and restarts the full sweep.
- **INIT side effects**
  - External writes (i_wr_en) are ignored.
  - Every o_read_data port is forced to 0.
- **READY writes**
  - i_wr_en=1 and i_write_addr≠0: write i_write_data to all banks at the write address.
  - i_write_addr==0: the write is suppressed.
- **x0**
  - A read with i_read_addr[p]==0 returns 0 regardless of bank contents or bypass.
- **Bypass (BYPASS_EN=1, READY only)**
  - Condition per port: i_wr_en, write address non-zero, and the write's {thread, addr} equals the read's {thread, addr} in the same cycle.
  - Effect: next cycle's o_read_data[p] equals that cycle's i_write_data.
  - Implementation: a registered hit flag and registered write data, muxed after the BRAM output. Do not rely on the BRAM read-during-write mode.
- **No bypass (BYPASS_EN=0)**
  - A same-cycle colliding read returns the pre-write value.
- **Output mux priority, per port**
  1. not-ready flag or x0 flag → 0
  2. bypass hit → forwarded data
  3. otherwise → BRAM dob
- All per-port flags are registered alongside the BRAM read.

## Timing
- **Read latency:** 1 cycle. Address presented in cycle N → data valid in cycle N+1.
- **Write-to-read across cycles:** a write in cycle N is visible to a read issued in N+1 (data in N+2), independent of BYPASS_EN.
- **Throughput:** 1 write and NUM_RD_PORTS reads per cycle.
- **Reset values**
  - o_init_done = 0.
  - o_read_data = 0 on all ports, via the registered not-ready flag = 1. The BRAM output register itself is not reset.
- **Sweep duration:** reset deasserts at edge E0 → writes occupy cycles 0..DEPTH-1 → o_init_done is high from edge E0+DEPTH onward.
  - DEPTH = 512 at default parameters.
  - Reads issued in the cycle o_init_done first reads 1 return real data one cycle later.
- **Counter width:** AW bits; it must not wrap before the READY transition.
- **Simultaneous reset and i_wr_en:** reset wins; nothing is written.

## Test plan
- **Sweep length:** NUM_THREADS=4. Preload garbage via backdoor, pulse reset 1 cycle.
  - o_init_done must rise exactly 128 cycles after deassert.
  - All 128 entries must read 0 afterwards.
- **Basic write/read:** thread 2, x5 ← 0xDEADBEEF; next cycle read x5 on port 0 and port 1 from thread 2.
  - Both return 0xDEADBEEF one cycle later.
  - Thread 3 x5 reads 0.
- **x0:** write 0x12345678 to x0 of thread 1, then read x0.
  - Result must be 0, with the bypass condition active and also on a later-cycle read.
- **Bypass:** same-cycle write x7 ← 0xA5A5A5A5 and read x7 (same thread).
  - BYPASS_EN=1: 0xA5A5A5A5.
  - BYPASS_EN=0: prior value 0x00000000.
  - A different thread in the same cycle: 0.
- **Reset mid-sweep:** assert reset at sweep cycle 50.
  - The sweep restarts; o_init_done rises DEPTH cycles after the second deassert.
- **Writes during INIT:** drive i_wr_en=1, x9 ← 0xFFFFFFFF during INIT.
  - o_read_data stays 0 throughout INIT.
  - x9 reads 0 after READY.
